// File: rtl/mem_stage_if.sv
// Signal bundle between the memory stage and its neighbours: EX-side handshake,
// WB-side handshake, data SRAM response, flushes and forwarding outputs.
interface mem_stage_if #(
   parameter int EX_TO_ME_W = 76,
   parameter int ME_TO_WB_W = 72
);
   logic                  EX_to_ME_Valid;
   logic [EX_TO_ME_W-1:0] EX_to_ME_Bus;
   logic                  ME_Allow_in;
   logic                  WB_Allow_in;
   logic                  ME_to_WB_Valid;
   logic [ME_TO_WB_W-1:0] ME_to_WB_Bus;
   logic                  data_sram_data_ok;
   logic [31:0]           data_sram_rdata;
   logic                  ertn_flush;
   logic                  excp_flush;
   logic [4:0]            ME_dest;
   logic [31:0]           ME_Forward_Res;
   logic                  ME_load_pending;

   modport master (
      output EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in,
             data_sram_data_ok, data_sram_rdata, ertn_flush, excp_flush,
      input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus,
             ME_dest, ME_Forward_Res, ME_load_pending
   );

   modport slave (
      input  EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in,
             data_sram_data_ok, data_sram_rdata, ertn_flush, excp_flush,
      output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus,
             ME_dest, ME_Forward_Res, ME_load_pending
   );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: holds one EX bundle, waits for the data SRAM response,
// aligns/extends load data and hands the result to WB.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  EMPTY     | no bundle held
//  WAIT_DATA | memory op held, waiting for its data_ok
//  READY     | result available, offered to WB
module mem_stage #(
   parameter int EX_TO_ME_W = 76,
   parameter int ME_TO_WB_W = 72
) (
   input  logic         clk,
   input  logic         resetn,
   mem_stage_if.slave   bus
);

   localparam logic [1:0] EMPTY     = 2'd0;
   localparam logic [1:0] WAIT_DATA = 2'd1;
   localparam logic [1:0] READY     = 2'd2;

   logic [1:0]  state;
   logic        me_valid;
   logic [1:0]  cancel_cnt;
   logic [31:0] rdata_buf;

   logic        syscall_r;
   logic        ertn_r;
   logic [2:0]  load_op_r;
   logic [31:0] pc_r;
   logic        gr_we_r;
   logic [4:0]  dest_r;
   logic [31:0] alu_r;

   logic        flush;
   logic        accept;
   logic        ex_mem_req;
   logic        data_consumed;
   logic        cancel_dec;
   logic        mine_outstanding;
   logic        ex_orphan;
   logic [2:0]  cancel_sum;
   logic [1:0]  cancel_next;
   logic        is_load;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] final_result;

   assign flush      = bus.ertn_flush | bus.excp_flush;
   assign ex_mem_req = bus.EX_to_ME_Bus[73];

   assign bus.ME_Allow_in    = ~me_valid | ((state == READY) & bus.WB_Allow_in);
   assign accept             = bus.EX_to_ME_Valid & bus.ME_Allow_in & ~flush;
   assign bus.ME_to_WB_Valid = me_valid & (state == READY) & ~flush;

   // A response arriving while cancel_cnt != 0 belongs to an abandoned request.
   assign cancel_dec       = bus.data_sram_data_ok & (cancel_cnt != 2'd0);
   assign data_consumed    = (state == WAIT_DATA) & bus.data_sram_data_ok & (cancel_cnt == 2'd0);
   assign mine_outstanding = (state == WAIT_DATA) & ~data_consumed;
   assign ex_orphan        = bus.EX_to_ME_Valid & ex_mem_req;

   always_comb begin
      cancel_sum = {1'b0, cancel_cnt} - {2'b00, cancel_dec};
      if (flush) begin
         cancel_sum = cancel_sum + {2'b00, mine_outstanding} + {2'b00, ex_orphan};
      end
      cancel_next = (cancel_sum > 3'd3) ? 2'd3 : cancel_sum[1:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= EMPTY;
         me_valid   <= 1'b0;
         cancel_cnt <= 2'd0;
         rdata_buf  <= 32'd0;
         syscall_r  <= 1'b0;
         ertn_r     <= 1'b0;
         load_op_r  <= 3'd0;
         pc_r       <= 32'd0;
         gr_we_r    <= 1'b0;
         dest_r     <= 5'd0;
         alu_r      <= 32'd0;
      end else begin
         cancel_cnt <= cancel_next;
         if (flush) begin
            me_valid <= 1'b0;
            state    <= EMPTY;
         end else begin
            if (accept) begin
               syscall_r <= bus.EX_to_ME_Bus[75];
               ertn_r    <= bus.EX_to_ME_Bus[74];
               load_op_r <= bus.EX_to_ME_Bus[72:70];
               pc_r      <= bus.EX_to_ME_Bus[69:38];
               gr_we_r   <= bus.EX_to_ME_Bus[37];
               dest_r    <= bus.EX_to_ME_Bus[36:32];
               alu_r     <= bus.EX_to_ME_Bus[31:0];
               me_valid  <= 1'b1;
               state     <= ex_mem_req ? WAIT_DATA : READY;
            end else if ((state == READY) && bus.WB_Allow_in) begin
               me_valid <= 1'b0;
               state    <= EMPTY;
            end
            if (data_consumed) begin
               rdata_buf <= bus.data_sram_rdata;
               state     <= READY;
            end
         end
      end
   end

   always_comb begin
      case (alu_r[1:0])
         2'd0:    byte_sel = rdata_buf[7:0];
         2'd1:    byte_sel = rdata_buf[15:8];
         2'd2:    byte_sel = rdata_buf[23:16];
         default: byte_sel = rdata_buf[31:24];
      endcase
      half_sel = alu_r[1] ? rdata_buf[31:16] : rdata_buf[15:0];
      is_load  = 1'b1;
      case (load_op_r)
         3'b001:  final_result = {{24{byte_sel[7]}}, byte_sel};
         3'b010:  final_result = {{16{half_sel[15]}}, half_sel};
         3'b011:  final_result = rdata_buf;
         3'b101:  final_result = {24'd0, byte_sel};
         3'b110:  final_result = {16'd0, half_sel};
         default: begin
            final_result = alu_r;
            is_load      = 1'b0;
         end
      endcase
   end

   assign bus.ME_to_WB_Bus    = {syscall_r, ertn_r, pc_r, gr_we_r, dest_r, final_result};
   assign bus.ME_dest         = dest_r & {5{me_valid & gr_we_r}};
   assign bus.ME_Forward_Res  = final_result;
   assign bus.ME_load_pending = me_valid & (state == WAIT_DATA) & is_load;

endmodule
